// File: rtl/led_target_demux.sv
// led_target_demux: routes one game target to one of 8 LEDs (registered 1:8
// demux), then times and judges the player's response on the matching buttons.
// Round flow: IDLE -> ARM -> LIT -> RESULT -> IDLE; every output is registered.
// Optional build macro AUTO_SEL_EN: the target index comes from an internal
// 8-bit Fibonacci LFSR (taps 8,6,5,4) instead of the sel input.
module led_target_demux #(
  parameter int ON_CYCLES = 1000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [7:0]       btn,
  output logic [7:0]       led,
  output logic [2:0]       tgt,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             miss,
  output logic [CNT_W-1:0] rt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    LIT    = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Last count value before a silent round times out, and the reported timeout time.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ON_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [7:0]       led_nxt;
  logic [2:0]       tgt_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             hit_nxt;
  logic             miss_nxt;
  logic [CNT_W-1:0] rt_nxt;
  logic [2:0]       sel_src;

  // One-hot decode of a 3-bit LED index.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

`ifdef AUTO_SEL_EN
  logic [7:0] lfsr;
  logic       unused_sel;

  // Free-running target generator; the sel input is not consulted in this build.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign sel_src    = lfsr[2:0];
  assign unused_sel = ^sel;
`else
  assign sel_src = sel;
`endif

  // State and output registers; reset also aborts a round in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      led   <= '0;
      tgt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hit   <= 1'b0;
      miss  <= 1'b0;
      rt    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      led   <= led_nxt;
      tgt   <= tgt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      hit   <= hit_nxt;
      miss  <= miss_nxt;
      rt    <= rt_nxt;
    end
  end

  // Next-state and next-output decisions for one round.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    led_nxt   = led;
    tgt_nxt   = tgt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    hit_nxt   = hit;
    miss_nxt  = miss;
    rt_nxt    = rt;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        led_nxt  = '0;
        if (start) begin
          state_nxt = ARM;
          tgt_nxt   = sel_src;
          hit_nxt   = 1'b0;
          miss_nxt  = 1'b0;
          rt_nxt    = '0;
          busy_nxt  = 1'b1;
        end
      end

      ARM: begin
        // Buttons already held when the round starts must be released first.
        if (btn == 8'h00) begin
          state_nxt = LIT;
          led_nxt   = onehot8(tgt);
          count_nxt = '0;
        end
      end

      LIT: begin
        // Any press is judged before the timeout, so a press on the last cycle wins.
        if (btn != 8'h00) begin
          if (btn == onehot8(tgt)) begin
            hit_nxt = 1'b1;
          end else begin
            miss_nxt = 1'b1;
          end
          rt_nxt    = count;
          led_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = RESULT;
        end else if (count == CNT_LAST) begin
          miss_nxt  = 1'b1;
          rt_nxt    = CNT_FULL;
          led_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = RESULT;
        end else begin
          count_nxt = count + 1'b1;
        end
      end

      RESULT: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        led_nxt   = '0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        led_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_target_demux.sv
// Testbench for led_target_demux: directed rounds from the feature list plus
// randomized rounds, each judged by a round-level model of the game rules.
module tb_led_target_demux;

  localparam int ON_CYCLES = 1000;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       sel;
  logic [7:0]       btn;
  logic [7:0]       led;
  logic [2:0]       tgt;
  logic             busy;
  logic             done;
  logic             hit;
  logic             miss;
  logic [CNT_W-1:0] rt;

  int total = 0;
  int bad   = 0;
  int unsigned ncyc = 0;

  led_target_demux #(.ON_CYCLES(ON_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .btn(btn),
    .led(led), .tgt(tgt), .busy(busy), .done(done),
    .hit(hit), .miss(miss), .rt(rt)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was released (positions the LFSR model).
  always @(posedge clk) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LFSR value after n clock steps from the reset seed.
  function automatic logic [7:0] lfsr_at(input int unsigned n);
    logic [7:0] v;
    v = 8'h01;
    for (int unsigned i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  // One full round. kind: 0 = correct press, 1 = wrong/multiple press, 2 = no press.
  // The press happens in the LIT cycle whose count equals d.
  task automatic round(input logic [2:0] s, input int pre, input logic [7:0] prepat,
                       input int d, input int kind, input logic [7:0] wrongpat,
                       input bit noise);
    logic [2:0] et;
    logic [7:0] eled, pat, lv;
    int         n, ert;
    bit         ehit;
`ifdef AUTO_SEL_EN
    lv = lfsr_at(ncyc);
    et = lv[2:0];
`else
    lv = 8'h00;
    et = s;
`endif
    eled = 8'b0000_0001 << et;
    ehit = (kind == 0);
    ert  = (kind == 2) ? ON_CYCLES : d;
    pat  = (kind == 0) ? eled : wrongpat;
    if (kind == 1 && (pat == 8'h00 || pat == eled)) pat = eled | (8'b0000_0001 << 3'(et + 3'd1));

    sel   = s;
    start = 1'b1;
    btn   = (pre > 0) ? prepat : 8'h00;
    tick();
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    sel   = 3'($urandom_range(0, 7));
    chk("arm_busy", 32'(busy), 1);
    chk("arm_led", 32'(led), 0);
    chk("tgt", 32'(tgt), 32'(et));
    chk("clr_hit", 32'(hit), 0);
    chk("clr_miss", 32'(miss), 0);
    chk("clr_rt", 32'(rt), 0);
    for (int i = 0; i < pre; i++) begin
      tick();
      chk("arm_hold_led", 32'(led), 0);
      chk("arm_hold_busy", 32'(busy), 1);
    end
    btn = 8'h00;
    tick();
    n = (kind == 2) ? ON_CYCLES : d;
    for (int i = 0; i < n; i++) begin
      chk("lit_led", 32'(led), 32'(eled));
      if (i == 0 || i == n - 1) chk("lit_done", 32'(done), 0);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        sel   = 3'($urandom_range(0, 7));
      end
      tick();
    end
    if (kind != 2) begin
      chk("lit_led_press", 32'(led), 32'(eled));
      btn = pat;
      tick();
    end
    btn   = 8'h00;
    start = noise ? 1'b1 : 1'b0;
    chk("res_done", 32'(done), 1);
    chk("res_busy", 32'(busy), 1);
    chk("res_led", 32'(led), 0);
    chk("res_hit", 32'(hit), 32'(ehit));
    chk("res_miss", 32'(miss), 32'(!ehit));
    chk("res_rt", 32'(rt), ert);
    chk("res_tgt", 32'(tgt), 32'(et));
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_led", 32'(led), 0);
    chk("idle_hit", 32'(hit), 32'(ehit));
    chk("idle_miss", 32'(miss), 32'(!ehit));
    chk("idle_rt", 32'(rt), ert);
    if (!noise) start = 1'b0;
  endtask

  initial begin
    logic [2:0] s;
    logic [7:0] pp, wp;
    int         pre, kind, d;

    rst   = 1'b1;
    start = 1'b1;
    sel   = 3'd3;
    btn   = 8'h00;
    tick();
    tick();
    chk("rst_led", 32'(led), 0);
    chk("rst_tgt", 32'(tgt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_miss", 32'(miss), 0);
    chk("rst_rt", 32'(rt), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_led", 32'(led), 0);

    round(3'd5, 0, 8'h00, 12, 0, 8'h00, 1'b0);
    round(3'd2, 3, 8'h04, 7, 1, 8'h05, 1'b0);
    round(3'd7, 0, 8'h00, 0, 2, 8'h00, 1'b0);
    round(3'd1, 0, 8'h00, ON_CYCLES - 1, 0, 8'h00, 1'b0);
    round(3'd4, 0, 8'h00, ON_CYCLES - 1, 1, 8'hff, 1'b0);
    round(3'd0, 0, 8'h00, 0, 0, 8'h00, 1'b0);
    round(3'd6, 2, 8'h40, 9, 0, 8'h00, 1'b1);
    round(3'd3, 0, 8'h00, 5, 1, 8'h01, 1'b1);

    // Reset in the middle of a lit round.
    start = 1'b0;
    tick();
    sel   = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("midlit_busy", 32'(busy), 1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    chk("midrst_led", 32'(led), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tgt", 32'(tgt), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rt", 32'(rt), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("midrst_idle_busy", 32'(busy), 0);

    for (int r = 0; r < 24; r++) begin
      s    = 3'($urandom_range(0, 7));
      pre  = int'($urandom_range(0, 2));
      pp   = 8'($urandom_range(1, 255));
      kind = (($urandom_range(0, 9)) == 0) ? 2 : int'($urandom_range(0, 1));
      d    = (($urandom_range(0, 7)) == 0) ? ON_CYCLES - 1 : int'($urandom_range(0, 30));
      wp   = 8'($urandom_range(1, 255));
      round(s, pre, pp, d, kind, wp, 1'($urandom_range(0, 1)));
    end

    start = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
